// File: rtl/mem_stage.sv
// Memory-access stage: runs word loads/stores on a req/ack bus and registers
// the write-back packet, stalling EX while an access is outstanding.
module mem_stage #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic        flush,
    input  logic [31:0] ex_data_out,
    input  logic [31:0] ex_store_data,
    input  logic [2:0]  ex_addr_dest,
    input  logic        ex_mem_inst,
    input  logic        ex_store,
    input  logic        ex_WR,
    input  logic        ex_link,
    input  logic [15:0] ex_link_pc,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_WR,
    output logic [2:0]  wb_addr_dest,
    output logic [31:0] wb_data,
    output logic        bus_err
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] timeoutCnt_q, timeoutCnt_d;
    logic [CW-1:0] cntInc;
    logic [29:0]   accAddr_q, accAddr_d;
    logic [31:0]   accWdata_q, accWdata_d;
    logic          accWe_q, accWe_d;
    logic [2:0]    accDest_q, accDest_d;
    logic          wbValid_q, wbValid_d;
    logic          wbWR_q, wbWR_d;
    logic [2:0]    wbDest_q, wbDest_d;
    logic [31:0]   wbData_q, wbData_d;
    logic          busErr_q, busErr_d;

    assign cntInc = timeoutCnt_q + CW'(1);

    // Next-state logic; ack is checked before timeout so a late ack still completes.
    always_comb begin
        state_d      = state_q;
        timeoutCnt_d = timeoutCnt_q;
        accAddr_d    = accAddr_q;
        accWdata_d   = accWdata_q;
        accWe_d      = accWe_q;
        accDest_d    = accDest_q;
        wbValid_d    = 1'b0;
        wbWR_d       = 1'b0;
        wbDest_d     = wbDest_q;
        wbData_d     = wbData_q;
        busErr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (!ex_mem_inst) begin
                        wbValid_d = 1'b1;
                        wbWR_d    = ex_WR;
                        wbDest_d  = ex_addr_dest;
                        wbData_d  = ex_link ? {16'b0, ex_link_pc} : ex_data_out;
                    end else if (ex_data_out[1:0] != 2'b00) begin
                        busErr_d = 1'b1;
                    end else begin
                        state_d      = ACCESS;
                        timeoutCnt_d = '0;
                        accAddr_d    = ex_data_out[31:2];
                        accWdata_d   = ex_store_data;
                        accWe_d      = ex_store;
                        accDest_d    = ex_addr_dest;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d   = IDLE;
                    accWe_d   = 1'b0;
                    wbValid_d = 1'b1;
                    wbWR_d    = !accWe_q;
                    wbDest_d  = accDest_q;
                    wbData_d  = accWe_q ? 32'h0 : dmem_rdata;
                end else if ((MEM_TIMEOUT != 0) && (cntInc == CW'(MEM_TIMEOUT))) begin
                    state_d  = IDLE;
                    accWe_d  = 1'b0;
                    busErr_d = 1'b1;
                end else begin
                    timeoutCnt_d = cntInc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q      <= IDLE;
            timeoutCnt_q <= '0;
            accAddr_q    <= '0;
            accWdata_q   <= '0;
            accWe_q      <= 1'b0;
            accDest_q    <= '0;
            wbValid_q    <= 1'b0;
            wbWR_q       <= 1'b0;
            wbDest_q     <= '0;
            wbData_q     <= '0;
            busErr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timeoutCnt_q <= timeoutCnt_d;
            accAddr_q    <= accAddr_d;
            accWdata_q   <= accWdata_d;
            accWe_q      <= accWe_d;
            accDest_q    <= accDest_d;
            wbValid_q    <= wbValid_d;
            wbWR_q       <= wbWR_d;
            wbDest_q     <= wbDest_d;
            wbData_q     <= wbData_d;
            busErr_q     <= busErr_d;
        end
    end

    assign stall        = (state_q != IDLE);
    assign dmem_req     = (state_q == ACCESS);
    assign dmem_we      = accWe_q;
    assign dmem_addr    = {accAddr_q, 2'b00};
    assign dmem_wdata   = accWdata_q;
    assign wb_valid     = wbValid_q;
    assign wb_WR        = wbWR_q;
    assign wb_addr_dest = wbDest_q;
    assign wb_data      = wbData_q;
    assign bus_err      = busErr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-back packets and bus errors
// are queued when an instruction is driven and retired by a monitor.
module tb_mem_stage;

   logic        clk;
   logic        resetn;
   logic        exValid;
   logic        flush;
   logic [31:0] exDataOut;
   logic [31:0] exStoreData;
   logic [2:0]  exAddrDest;
   logic        exMemInst;
   logic        exStore;
   logic        exWR;
   logic        exLink;
   logic [15:0] exLinkPc;
   logic        stall;
   logic        dmemReq;
   logic        dmemWe;
   logic [31:0] dmemAddr;
   logic [31:0] dmemWdata;
   logic        dmemAck;
   logic [31:0] dmemRdata;
   logic        wbValid;
   logic        wbWR;
   logic [2:0]  wbAddrDest;
   logic [31:0] wbData;
   logic        busErr;

   typedef struct {
      logic        isErr;
      logic        wr;
      logic [2:0]  dest;
      logic [31:0] data;
   } pkt_t;

   pkt_t sb[$];
   int   total = 0;
   int   bad = 0;

   mem_stage #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .resetn(resetn), .ex_valid(exValid), .flush(flush),
      .ex_data_out(exDataOut), .ex_store_data(exStoreData), .ex_addr_dest(exAddrDest),
      .ex_mem_inst(exMemInst), .ex_store(exStore), .ex_WR(exWR), .ex_link(exLink),
      .ex_link_pc(exLinkPc), .stall(stall), .dmem_req(dmemReq), .dmem_we(dmemWe),
      .dmem_addr(dmemAddr), .dmem_wdata(dmemWdata), .dmem_ack(dmemAck),
      .dmem_rdata(dmemRdata), .wb_valid(wbValid), .wb_WR(wbWR),
      .wb_addr_dest(wbAddrDest), .wb_data(wbData), .bus_err(busErr)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
      end
   endtask

   // Presents one instruction for a single cycle, leaves the bench at the next negedge
   task automatic applyStimulus(input logic mem, input logic st, input logic [31:0] data,
                                input logic [31:0] sdata, input logic [2:0] dest,
                                input logic wr, input logic lnk, input logic [15:0] pc);
      exValid     = 1'b1;
      exMemInst   = mem;
      exStore     = st;
      exDataOut   = data;
      exStoreData = sdata;
      exAddrDest  = dest;
      exWR        = wr;
      exLink      = lnk;
      exLinkPc    = pc;
      @(negedge clk);
      exValid = 1'b0;
   endtask

   task automatic expectPkt(input logic err, input logic wr, input logic [2:0] dest, input logic [31:0] data);
      pkt_t p;
      p.isErr = err;
      p.wr    = wr;
      p.dest  = dest;
      p.data  = data;
      sb.push_back(p);
   endtask

   // Monitor retires one scoreboard entry per wb_valid or bus_err pulse
   always @(negedge clk) begin
      if (!resetn && (wbValid || busErr)) begin
         checkOutput("wb_err_exclusive", 32'(wbValid & busErr), 32'd0);
         if (sb.size() == 0) begin
            checkOutput("unexpected_output", {30'd0, wbValid, busErr}, 32'd0);
         end else begin
            pkt_t p;
            p = sb.pop_front();
            checkOutput("out_kind", {30'd0, wbValid, busErr}, p.isErr ? 32'd1 : 32'd2);
            if (!p.isErr) begin
               checkOutput("wb_WR", 32'(wbWR), 32'(p.wr));
               checkOutput("wb_addr_dest", 32'(wbAddrDest), 32'(p.dest));
               checkOutput("wb_data", wbData, p.data);
            end
         end
      end
   end

   // Directed sequence covering ALU, link, load, store, timeout, misalign, reset and flush
   initial begin
      resetn = 1'b1; exValid = 1'b0; flush = 1'b0; exDataOut = '0; exStoreData = '0;
      exAddrDest = '0; exMemInst = 1'b0; exStore = 1'b0; exWR = 1'b0; exLink = 1'b0;
      exLinkPc = '0; dmemAck = 1'b0; dmemRdata = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_req", 32'(dmemReq), 32'd0);
      checkOutput("rst_we", 32'(dmemWe), 32'd0);
      checkOutput("rst_addr", dmemAddr, 32'd0);
      checkOutput("rst_wdata", dmemWdata, 32'd0);
      checkOutput("rst_wb", {wbValid, wbWR, busErr, wbAddrDest}, 32'd0);
      checkOutput("rst_wbdata", wbData, 32'd0);
      resetn = 1'b0;
      @(negedge clk);

      // ALU result
      expectPkt(1'b0, 1'b1, 3'd3, 32'h0000_1234);
      applyStimulus(1'b0, 1'b0, 32'h1234, 32'h0, 3'd3, 1'b1, 1'b0, 16'h0);
      checkOutput("alu_stall", 32'(stall), 32'd0);
      checkOutput("alu_wbvalid", 32'(wbValid), 32'd1);

      // Link write of return address
      expectPkt(1'b0, 1'b1, 3'd7, 32'h0000_0042);
      applyStimulus(1'b0, 1'b0, 32'h9999_0000, 32'h0, 3'd7, 1'b1, 1'b1, 16'h0042);
      checkOutput("link_wbvalid", 32'(wbValid), 32'd1);

      // Load acked in the third request cycle; flush mid-access must be ignored
      expectPkt(1'b0, 1'b1, 3'd2, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 3'd2, 1'b0, 1'b0, 16'h0);
      for (int i = 1; i <= 3; i++) begin
         if (i > 1) @(negedge clk);
         flush = (i == 2);
         checkOutput("ld_req", 32'(dmemReq), 32'd1);
         checkOutput("ld_stall", 32'(stall), 32'd1);
         checkOutput("ld_addr", dmemAddr, 32'h100);
         checkOutput("ld_we", 32'(dmemWe), 32'd0);
         if (i == 3) begin
            dmemAck = 1'b1;
            dmemRdata = 32'hDEAD_BEEF;
         end
      end
      flush = 1'b0;
      @(negedge clk);
      dmemAck = 1'b0;
      checkOutput("ld_req_drop", 32'(dmemReq), 32'd0);
      checkOutput("ld_stall_drop", 32'(stall), 32'd0);

      // Store acked in the first request cycle
      expectPkt(1'b0, 1'b0, 3'd5, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h40, 32'hA5A5_A5A5, 3'd5, 1'b1, 1'b0, 16'h0);
      checkOutput("st_req", 32'(dmemReq), 32'd1);
      checkOutput("st_we", 32'(dmemWe), 32'd1);
      checkOutput("st_addr", dmemAddr, 32'h40);
      checkOutput("st_wdata", dmemWdata, 32'hA5A5_A5A5);
      dmemAck = 1'b1;
      @(negedge clk);
      dmemAck = 1'b0;
      checkOutput("st_we_drop", 32'(dmemWe), 32'd0);
      checkOutput("st_req_drop", 32'(dmemReq), 32'd0);

      // Load never acked: four request cycles then a bus error
      expectPkt(1'b1, 1'b0, 3'd0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 3'd1, 1'b1, 1'b0, 16'h0);
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) @(negedge clk);
         checkOutput("to_req", 32'(dmemReq), 32'd1);
      end
      @(negedge clk);
      checkOutput("to_req_drop", 32'(dmemReq), 32'd0);
      checkOutput("to_stall_drop", 32'(stall), 32'd0);
      checkOutput("to_buserr", 32'(busErr), 32'd1);

      // Misaligned load: no request, bus error next cycle
      expectPkt(1'b1, 1'b0, 3'd0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, 3'd4, 1'b1, 1'b0, 16'h0);
      checkOutput("mis_req", 32'(dmemReq), 32'd0);
      checkOutput("mis_stall", 32'(stall), 32'd0);
      checkOutput("mis_buserr", 32'(busErr), 32'd1);

      // Reset during an access, then a stray ack afterwards
      applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 3'd6, 1'b1, 1'b0, 16'h0);
      checkOutput("rstacc_req", 32'(dmemReq), 32'd1);
      resetn = 1'b1;
      @(negedge clk);
      resetn = 1'b0;
      checkOutput("rstacc_req_drop", 32'(dmemReq), 32'd0);
      dmemAck = 1'b1;
      dmemRdata = 32'h1111_2222;
      @(negedge clk);
      dmemAck = 1'b0;
      checkOutput("rstacc_stall", 32'(stall), 32'd0);
      checkOutput("rstacc_req_idle", 32'(dmemReq), 32'd0);

      // Flushed instruction in IDLE produces nothing
      flush = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h5555, 32'h0, 3'd1, 1'b1, 1'b0, 16'h0);
      flush = 1'b0;
      checkOutput("flush_wbvalid", 32'(wbValid), 32'd0);
      checkOutput("flush_stall", 32'(stall), 32'd0);

      repeat (3) @(negedge clk);
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
